bus_ctrl: RTL and testbench

Parametrised bus controller sitting between `top_cpu` and the memory-mapped slaves inside the core top level. It takes single CPU transactions over a request/acknowledge handshake and decodes the upper address bits to one of `NUM_SLV` slaves. It waits out slave wait states, returns read data, and reports unmapped addresses and (optionally) timed-out accesses as bus errors.

---
 rtl/bus_ctrl_if.sv | 38 +++
 rtl/bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_bus_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_ctrl_if.sv
// Bundle of CPU-side and slave-side signals around bus_ctrl.
// master = the controller's view, slave = the CPU/slave environment's view.
interface bus_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    // Handshake: the CPU raises cpu_bc_req with rw/addr/data stable and holds it
    // until it sees bc_cpu_ack (a one-cycle pulse, bc_cpu_err valid alongside);
    // bc_slv_req[i] is held until slv_bc_ack[i], which may be combinational.
    logic                      cpu_bc_req;
    logic                      cpu_bc_rw;
    logic [ADDR_W-1:0]         cpu_bc_addr;
    logic [DATA_W-1:0]         cpu_bc_data;
    logic [DATA_W-1:0]         bc_cpu_data;
    logic                      bc_cpu_ack;
    logic                      bc_cpu_err;
    logic [NUM_SLV-1:0]        bc_slv_req;
    logic                      bc_slv_rw;
    logic [ADDR_W-1:0]         bc_slv_addr;
    logic [DATA_W-1:0]         bc_slv_data;
    logic [NUM_SLV*DATA_W-1:0] slv_bc_data;
    logic [NUM_SLV-1:0]        slv_bc_ack;

    modport master (
        input  cpu_bc_req, cpu_bc_rw, cpu_bc_addr, cpu_bc_data,
        input  slv_bc_data, slv_bc_ack,
        output bc_cpu_data, bc_cpu_ack, bc_cpu_err,
        output bc_slv_req, bc_slv_rw, bc_slv_addr, bc_slv_data
    );

    modport slave (
        output cpu_bc_req, cpu_bc_rw, cpu_bc_addr, cpu_bc_data,
        output slv_bc_data, slv_bc_ack,
        input  bc_cpu_data, bc_cpu_ack, bc_cpu_err,
        input  bc_slv_req, bc_slv_rw, bc_slv_addr, bc_slv_data
    );
endinterface

// File: rtl/bus_ctrl.sv
// Single-transaction bus controller: decodes top address bits to one of NUM_SLV slaves.
// Optional access timeout enabled by defining BC_TIMEOUT_EN.
module bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 2,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    bus_ctrl_if.master  bus,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    if (TIMEOUT < 1 || NUM_SLV > (1 << IDX_W)) begin : g_bad_cfg
        $error("bus_ctrl: TIMEOUT must be >= 1 and NUM_SLV <= 2**IDX_W");
    end

    state_t             state_q;
    logic               rw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_SLV-1:0] slv_req_q;
    logic               ack_q;
    logic               err_q;

    logic [IDX_W-1:0]   idx_d;
    logic               mapped_d;
    logic [NUM_SLV-1:0] onehot_d;
    logic               sel_ack;
    logic [DATA_W-1:0]  sel_data;
    logic               timeout_d;

    assign idx_d    = bus.cpu_bc_addr[ADDR_W-1 -: IDX_W];
    assign mapped_d = ({1'b0, idx_d} < (IDX_W+1)'(NUM_SLV));

    // Only the latched slave's ack/data are looked at; everyone else is ignored.
    always_comb begin
        onehot_d = '0;
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            onehot_d[i] = (idx_d == IDX_W'(i));
            if (idx_q == IDX_W'(i)) begin
                sel_ack  = bus.slv_bc_ack[i];
                sel_data = bus.slv_bc_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    // cnt_q holds (ACCESS cycle number - 1), so this fires in the TIMEOUT-th cycle.
    assign timeout_d = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            idx_q     <= '0;
            slv_req_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef BC_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (bus.cpu_bc_req) begin
                        rw_q    <= bus.cpu_bc_rw;
                        addr_q  <= bus.cpu_bc_addr;
                        wdata_q <= bus.cpu_bc_data;
                        idx_q   <= idx_d;
                        if (mapped_d) begin
                            slv_req_q <= onehot_d;
                            state_q   <= ACCESS;
`ifdef BC_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end else begin
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= DONE;
                            if (!bus.cpu_bc_rw) rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ack) begin
                        slv_req_q <= '0;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= DONE;
                        if (!rw_q) rdata_q <= sel_data;
                    end else if (timeout_d) begin
                        slv_req_q <= '0;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                        if (!rw_q) rdata_q <= '0;
                    end
`ifdef BC_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bc_cpu_data = rdata_q;
    assign bus.bc_cpu_ack  = ack_q;
    assign bus.bc_cpu_err  = err_q;
    assign bus.bc_slv_req  = slv_req_q;
    assign bus.bc_slv_rw   = rw_q;
    assign bus.bc_slv_addr = addr_q;
    assign bus.bc_slv_data = wdata_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: a 4-slave instance (TIMEOUT=4) and a 3-slave instance
// for the unmapped-address case. Responses are checked against an expected queue.
module tb_bus_ctrl;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 4;
    localparam int NS3 = 3;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS))  bus ();
    bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS3)) bus3 ();
    logic [1:0] state;
    logic [1:0] state3;

    bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(2), .NUM_SLV(NS), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .state_o(state)
    );
    bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(2), .NUM_SLV(NS3), .TIMEOUT(15)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .state_o(state3)
    );

    // scoreboard: {err, data}
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] model_rdata;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [DW:0] got);
        logic [DW:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 64'(got), 64'h1_0000_0000_dead);
        end else begin
            exp = exp_q.pop_front();
            check(tag, 64'(got), 64'(exp));
        end
    endtask

    // Driver + responding slave for the 4-slave instance. Called in an IDLE cycle
    // (just after a negedge); returns at the negedge inside the DONE cycle.
    task automatic txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int slv, input int waits, input int noise, input logic exp_err,
                       input int exp_lat, input logic [DW-1:0] slv_rdata, input bit drop_req);
        int cyc = 0;
        int acc = 0;
        bit seen = 0;
        logic [NS-1:0] oh;
        oh = '0;
        oh[slv] = 1'b1;
        if (!rw) model_rdata = exp_err ? '0 : slv_rdata;
        exp_q.push_back({exp_err, model_rdata});
        bus.cpu_bc_req  = 1'b1;
        bus.cpu_bc_rw   = rw;
        bus.cpu_bc_addr = addr;
        bus.cpu_bc_data = wdata;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.slv_bc_ack = '0;
            for (int i = 0; i < NS; i++) bus.slv_bc_data[i*DW +: DW] = $urandom;
            if (bus.bc_cpu_ack) begin
                seen = 1;
                check_rsp("rsp", {bus.bc_cpu_err, bus.bc_cpu_data});
                check("latency", 64'(cyc), 64'(exp_lat));
                check("req_done", 64'(bus.bc_slv_req), 64'd0);
                check("state_done", 64'(state), 64'(ST_DONE));
                if (drop_req) bus.cpu_bc_req = 1'b0;
            end else begin
                check("state_access", 64'(state), 64'(ST_ACCESS));
                check("slv_req", 64'(bus.bc_slv_req), 64'(oh));
                check("slv_rw", 64'(bus.bc_slv_rw), 64'(rw));
                check("slv_addr", 64'(bus.bc_slv_addr), 64'(addr));
                check("slv_data", 64'(bus.bc_slv_data), 64'(wdata));
                acc++;
                if (acc == waits + 1) begin
                    bus.slv_bc_ack[slv] = 1'b1;
                    bus.slv_bc_data[slv*DW +: DW] = slv_rdata;
                end
                if (noise >= 0) bus.slv_bc_ack[noise] = 1'b1;
                // CPU inputs wander while the transaction is latched
                bus.cpu_bc_addr = $urandom;
                bus.cpu_bc_data = $urandom;
                bus.cpu_bc_rw   = ~bus.cpu_bc_rw;
            end
        end
        if (!seen) check("ack_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic idle_step();
        @(negedge clk);
        bus.slv_bc_ack = '0;
        check("ack_pulse_end", 64'(bus.bc_cpu_ack), 64'd0);
        check("state_idle", 64'(state), 64'(ST_IDLE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.cpu_bc_req = 1'b0; bus.cpu_bc_rw = 1'b0; bus.cpu_bc_addr = '0; bus.cpu_bc_data = '0;
        bus.slv_bc_ack = '0;   bus.slv_bc_data = '0;
        bus3.cpu_bc_req = 1'b0; bus3.cpu_bc_rw = 1'b0; bus3.cpu_bc_addr = '0; bus3.cpu_bc_data = '0;
        bus3.slv_bc_ack = 3'b111;
        bus3.slv_bc_data = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        model_rdata = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_state", 64'(state), 64'(ST_IDLE));
        check("rst_ack", 64'(bus.bc_cpu_ack), 64'd0);
        check("rst_err", 64'(bus.bc_cpu_err), 64'd0);
        check("rst_data", 64'(bus.bc_cpu_data), 64'd0);
        check("rst_slv_req", 64'(bus.bc_slv_req), 64'd0);
        check("rst_slv_bus", 64'({bus.bc_slv_rw, bus.bc_slv_addr, bus.bc_slv_data}), 64'd0);
        check("rst3_outs", 64'({bus3.bc_cpu_ack, bus3.bc_cpu_err, bus3.bc_slv_req}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // read, zero wait, slave 1
        txn(1'b0, 32'h4000_0010, 32'h0, 1, 0, -1, 1'b0, 2, 32'hDEAD_BEEF, 1);
        idle_step();
        check("read_data_hold", 64'(bus.bc_cpu_data), 64'h0000_0000_DEAD_BEEF);

        // write, 3 wait states, slave 2; read data must be untouched
        txn(1'b1, 32'h8000_0004, 32'h1234_5678, 2, 3, -1, 1'b0, 5, 32'h0, 1);
        idle_step();
        check("write_keeps_data", 64'(bus.bc_cpu_data), 64'h0000_0000_DEAD_BEEF);

`ifdef BC_TIMEOUT_EN
        // slave 0 never acks (slave 3 chatters): error after 4 ACCESS cycles
        txn(1'b0, 32'h0000_0100, 32'h0, 0, 1000, 3, 1'b1, 5, 32'h0, 1);
        idle_step();
        // ack in the 4th ACCESS cycle beats the timeout
        txn(1'b0, 32'h0000_0200, 32'h0, 0, 3, 3, 1'b0, 5, 32'hA5A5_0001, 1);
        idle_step();
`else
        // long wait well past TIMEOUT with slave 3 chattering; no error without the timeout
        txn(1'b0, 32'h0000_0100, 32'h0, 0, 20, 3, 1'b0, 22, 32'hCAFE_0000, 1);
        idle_step();
`endif

        // back-to-back reads, slave 0 then slave 3, req held high
        txn(1'b0, 32'h0000_0040, 32'h0, 0, 0, -1, 1'b0, 2, 32'h1111_0000, 0);
        @(negedge clk);
        bus.slv_bc_ack = '0;
        check("b2b_idle", 64'(state), 64'(ST_IDLE));
        txn(1'b0, 32'hC000_0080, 32'h0, 3, 0, -1, 1'b0, 2, 32'h3333_0003, 1);
        idle_step();

        // 3-slave instance: mapped read to slave 2, then an unmapped read
        bus3.cpu_bc_req = 1'b1; bus3.cpu_bc_rw = 1'b0; bus3.cpu_bc_addr = 32'h8000_0000;
        exp_q.push_back({1'b0, 32'h3333_0002});
        @(negedge clk);
        check("u3_access_req", 64'(bus3.bc_slv_req), 64'b100);
        @(negedge clk);
        check("u3_ack", 64'(bus3.bc_cpu_ack), 64'd1);
        check_rsp("u3_rsp", {bus3.bc_cpu_err, bus3.bc_cpu_data});
        bus3.cpu_bc_req = 1'b0;
        @(negedge clk);
        bus3.cpu_bc_req = 1'b1; bus3.cpu_bc_addr = 32'hC000_0000;
        exp_q.push_back({1'b1, 32'h0});
        @(negedge clk);
        check("unmapped_ack", 64'(bus3.bc_cpu_ack), 64'd1);
        check("unmapped_req", 64'(bus3.bc_slv_req), 64'd0);
        check("unmapped_state", 64'(state3), 64'(ST_DONE));
        check_rsp("unmapped_rsp", {bus3.bc_cpu_err, bus3.bc_cpu_data});
        bus3.cpu_bc_req = 1'b0;
        @(negedge clk);
        check("unmapped_after", 64'({bus3.bc_cpu_ack, bus3.bc_slv_req}), 64'd0);
        check("unmapped_idle", 64'(state3), 64'(ST_IDLE));

        // reset in the 2nd ACCESS cycle abandons the read
        bus.cpu_bc_req = 1'b1; bus.cpu_bc_rw = 1'b0; bus.cpu_bc_addr = 32'h4000_0000;
        bus.cpu_bc_data = 32'h0;
        @(negedge clk);
        check("rst_mid_access", 64'(state), 64'(ST_ACCESS));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.cpu_bc_req = 1'b0;
        check("rstmid_state", 64'(state), 64'(ST_IDLE));
        check("rstmid_ack", 64'({bus.bc_cpu_ack, bus.bc_cpu_err}), 64'd0);
        check("rstmid_data", 64'(bus.bc_cpu_data), 64'd0);
        check("rstmid_slv", 64'({bus.bc_slv_req, bus.bc_slv_rw, bus.bc_slv_addr, bus.bc_slv_data}), 64'd0);
        model_rdata = '0;
        idle_step();
        txn(1'b0, 32'h4000_0010, 32'h0, 1, 1, -1, 1'b0, 3, 32'h5555_AAAA, 1);
        idle_step();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
